wash_sequencer: RTL and testbench

- Run-phase controller for the washing machine.
- Latches the 26-bit program word produced by the mode/time setter and sequences the eight wash/rinse phases against a 1 Hz tick.
- Drives the water valve, drain valve and motor, and handles pause and door-open error.
- Sits between the setting logic (program word) and the actuator/display outputs.

---
 rtl/wash_ctrl_pkg.sv | 44 ++++
 rtl/next_phase_find.sv | 28 ++
 rtl/wash_sequencer.sv | 158 +++++++++++++++
 tb/tb_wash_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_ctrl_pkg.sv
// Shared encodings for the wash run-phase controller: run states, phases,
// program-word field layout and the phase-to-actuator mapping.
package wash_ctrl_pkg;

  localparam int unsigned PROG_W   = 26;
  localparam int unsigned N_PHASES = 8;

  typedef enum logic [2:0] {
    RS_IDLE   = 3'd0,
    RS_RUN    = 3'd1,
    RS_PAUSE  = 3'd2,
    RS_ERROR  = 3'd3,
    RS_FINISH = 3'd4
  } run_state_e;

  typedef enum logic [2:0] {
    PH_W_FILL  = 3'd0,
    PH_WASH    = 3'd1,
    PH_W_DRAIN = 3'd2,
    PH_W_SPIN  = 3'd3,
    PH_R_FILL  = 3'd4,
    PH_RINSE   = 3'd5,
    PH_R_DRAIN = 3'd6,
    PH_R_SPIN  = 3'd7
  } phase_e;

  // Field LSB per phase (element 0 = W_FILL); WASH and RINSE are 4 bits wide.
  localparam logic [7:0][4:0] FIELD_LSB  = {5'd0, 5'd3, 5'd6, 5'd10,
                                            5'd13, 5'd16, 5'd19, 5'd23};
  localparam logic [7:0]      FIELD_WIDE = 8'b0010_0010;

  // Bit n set = actuator on while running in phase n.
  localparam logic [7:0] WATER_MASK = 8'b0001_0001;
  localparam logic [7:0] MOTOR_MASK = 8'b1010_1010;
  localparam logic [7:0] DRAIN_MASK = 8'b1100_1100;

  function automatic logic [3:0] field_of(input logic [PROG_W-1:0] p,
                                          input logic [2:0]        idx);
    logic [PROG_W-1:0] shifted;
    shifted = p >> FIELD_LSB[idx];
    return FIELD_WIDE[idx] ? shifted[3:0] : {1'b0, shifted[2:0]};
  endfunction

endpackage

// File: rtl/next_phase_find.sv
// Finds the first phase at or after start_idx_i whose program field is
// nonzero, returning its index and duration.
module next_phase_find
  import wash_ctrl_pkg::*;
(
  input  logic [PROG_W-1:0] prog_i,
  input  logic [3:0]        start_idx_i,
  output logic [2:0]        next_phase_o,
  output logic [3:0]        next_dur_o,
  output logic              none_left_o
);

  always_comb begin
    logic found;
    found        = 1'b0;
    next_phase_o = '0;
    next_dur_o   = '0;
    for (int unsigned i = 0; i < N_PHASES; i++) begin
      if (!found && (4'(i) >= start_idx_i) && (field_of(prog_i, 3'(i)) != '0)) begin
        found        = 1'b1;
        next_phase_o = 3'(i);
        next_dur_o   = field_of(prog_i, 3'(i));
      end
    end
    none_left_o = !found;
  end

endmodule

// File: rtl/wash_sequencer.sv
// Run-phase controller: latches the program word, steps the eight wash/rinse
// phases on the 1 Hz tick and drives valves and motor, with pause and door error.
module wash_sequencer
  import wash_ctrl_pkg::*;
#(
  parameter int unsigned PH_W  = 3,
  parameter int unsigned TOT_W = 8
) (
  input  logic              cp,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic              pause,
  input  logic              door_open,
  input  logic [25:0]       prog,
  output logic [2:0]        run_state,
  output logic [PH_W-1:0]   phase,
  output logic [3:0]        remain,
  output logic [TOT_W-1:0]  total_remain,
  output logic              water_valve,
  output logic              drain_valve,
  output logic              motor,
  output logic              done
);

  run_state_e          state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [3:0]          remain_q, remain_d;
  logic [TOT_W-1:0]    total_q, total_d;
  logic [PROG_W-1:0]   prog_q, prog_d;
  logic                water_q, water_d, drain_q, drain_d, motor_q, motor_d;
  logic                done_q, done_d;

  logic [PROG_W-1:0]   find_prog;
  logic [3:0]          find_start;
  logic [2:0]          nf_phase;
  logic [3:0]          nf_dur;
  logic                nf_none;
  logic [TOT_W-1:0]    load_total;

  // One finder serves both the initial load (live prog from index 0) and
  // advancing (latched prog from the phase after the current one).
  assign find_prog  = (state_q == RS_IDLE) ? prog : prog_q;
  assign find_start = (state_q == RS_IDLE) ? 4'd0 : ({1'b0, phase_q} + 4'd1);

  next_phase_find u_find (
    .prog_i       (find_prog),
    .start_idx_i  (find_start),
    .next_phase_o (nf_phase),
    .next_dur_o   (nf_dur),
    .none_left_o  (nf_none)
  );

  always_comb begin
    load_total = '0;
    for (int unsigned i = 0; i < N_PHASES; i++) begin
      load_total = load_total + TOT_W'(field_of(prog, 3'(i)));
    end
  end

  always_ff @(posedge cp) begin
    if (rst) begin
      state_q  <= RS_IDLE;
      phase_q  <= PH_W_FILL;
      remain_q <= '0;
      total_q  <= '0;
      prog_q   <= '0;
      water_q  <= 1'b0;
      drain_q  <= 1'b0;
      motor_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
      total_q  <= total_d;
      prog_q   <= prog_d;
      water_q  <= water_d;
      drain_q  <= drain_d;
      motor_q  <= motor_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    total_d  = total_q;
    prog_d   = prog_q;
    done_d   = 1'b0;
    case (state_q)
      RS_IDLE: begin
        if (start && (prog != '0)) begin
          prog_d   = prog;
          phase_d  = phase_e'(nf_phase);
          remain_d = nf_dur;
          total_d  = load_total;
          state_d  = RS_RUN;
        end
      end
      RS_RUN: begin
        if (door_open) begin
          state_d = RS_ERROR;
        end else if (pause) begin
          state_d = RS_PAUSE;
        end else if (tick) begin
          if (total_q != '0) total_d = total_q - TOT_W'(1);
          if (remain_q > 4'd1) begin
            remain_d = remain_q - 4'd1;
          end else if (!nf_none) begin
            phase_d  = phase_e'(nf_phase);
            remain_d = nf_dur;
          end else begin
            state_d  = RS_FINISH;
            remain_d = '0;
            total_d  = '0;
            done_d   = 1'b1;
          end
        end
      end
      RS_PAUSE: begin
        if (door_open)  state_d = RS_ERROR;
        else if (pause) state_d = RS_RUN;
      end
      RS_ERROR: begin
        if (start && !door_open) state_d = RS_RUN;
      end
      RS_FINISH: begin
        if (start) begin
          state_d  = RS_IDLE;
          phase_d  = PH_W_FILL;
          remain_d = '0;
        end
      end
      default: state_d = RS_IDLE;
    endcase
  end

  always_comb begin
    water_d = (state_d == RS_RUN) && WATER_MASK[phase_d];
    motor_d = (state_d == RS_RUN) && MOTOR_MASK[phase_d];
    drain_d = (state_d == RS_RUN) && DRAIN_MASK[phase_d];
  end

  assign run_state    = state_q;
  assign phase        = PH_W'(phase_q);
  assign remain       = remain_q;
  assign total_remain = total_q;
  assign water_valve  = water_q;
  assign drain_valve  = drain_q;
  assign motor        = motor_q;
  assign done         = done_q;

  a_no_underflow: assert property (@(posedge cp) disable iff (rst)
    (state_q == RS_RUN && tick && !door_open && !pause) |-> (total_q != '0));

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed self-checking bench for wash_sequencer.
module tb_wash_sequencer;

  logic        cp = 1'b0;
  logic        rst, tick, start, pause, door_open;
  logic [25:0] prog;
  logic [2:0]  run_state;
  logic [2:0]  phase;
  logic [3:0]  remain;
  logic [7:0]  total_remain;
  logic        water_valve, drain_valve, motor, done;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [25:0] FULL       = {3'd3, 4'd10, 3'd4, 3'd5, 3'd3, 4'd8, 3'd4, 3'd5};
  localparam logic [25:0] RINSE_ONLY = {13'd0, 3'd3, 4'd8, 3'd4, 3'd5};
  localparam logic [25:0] SPIN_ONLY  = {10'd0, 3'd2, 13'd0};

  wash_sequencer #(.PH_W(3), .TOT_W(8)) dut (
    .cp           (cp),
    .rst          (rst),
    .tick         (tick),
    .start        (start),
    .pause        (pause),
    .door_open    (door_open),
    .prog         (prog),
    .run_state    (run_state),
    .phase        (phase),
    .remain       (remain),
    .total_remain (total_remain),
    .water_valve  (water_valve),
    .drain_valve  (drain_valve),
    .motor        (motor),
    .done         (done)
  );

  always #5 cp = ~cp;

  // {run_state, phase, remain, total, water, drain, motor, done}
  function automatic logic [21:0] snap();
    return {run_state, phase, remain, total_remain, water_valve, drain_valve, motor, done};
  endfunction

  function automatic logic [21:0] expv(input logic [2:0] st, input logic [2:0] ph,
                                       input logic [3:0] rm, input logic [7:0] tot,
                                       input logic [2:0] act, input logic dn);
    return {st, ph, rm, tot, act, dn};
  endfunction

  // {water, drain, motor} while running in a phase
  function automatic logic [2:0] act_of(input logic [2:0] ph);
    case (ph)
      3'd0, 3'd4: return 3'b100;
      3'd1, 3'd5: return 3'b001;
      3'd2, 3'd6: return 3'b010;
      default:    return 3'b011;
    endcase
  endfunction

  task automatic step(input logic t, input logic s, input logic p);
    tick = t; start = s; pause = p;
    @(negedge cp);
    tick = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; door_open = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic load(input logic [25:0] p);
    prog = p;
    step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [21:0] got, want;
    tick = 0; start = 0; pause = 0; door_open = 0; prog = FULL;
    do_reset();
    got = snap(); want = expv(3'd0, 3'd0, 4'd0, 8'd0, 3'b000, 1'b0);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL reset got=%h want=%h", got, want); end
  endtask

  task automatic test_full();
    logic [21:0] got, want;
    int bnd[8] = '{0, 3, 13, 17, 22, 25, 33, 37};
    int dur[8] = '{3, 10, 4, 5, 3, 8, 4, 5};
    int p;
    do_reset();
    load(FULL);
    prog = '0;
    got = snap(); want = expv(3'd1, 3'd0, 4'd3, 8'd42, 3'b100, 1'b0);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL full_load got=%h want=%h", got, want); end
    for (int k = 1; k <= 41; k++) begin
      step(1'b1, 1'b0, 1'b0);
      p = 0;
      for (int j = 0; j < 8; j++) if (bnd[j] <= k) p = j;
      got  = snap();
      want = expv(3'd1, 3'(p), 4'(dur[p] - (k - bnd[p])), 8'(42 - k), act_of(3'(p)), 1'b0);
      tests_run++;
      if (got !== want) begin tests_failed++; $display("FAIL full_tick%0d got=%h want=%h", k, got, want); end
    end
    step(1'b1, 1'b0, 1'b0);
    got = snap(); want = expv(3'd4, 3'd7, 4'd0, 8'd0, 3'b000, 1'b1);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL full_done got=%h want=%h", got, want); end
    step(1'b0, 1'b0, 1'b0);
    got = snap(); want = expv(3'd4, 3'd7, 4'd0, 8'd0, 3'b000, 1'b0);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL full_done_pulse got=%h want=%h", got, want); end
    step(1'b0, 1'b1, 1'b0);
    got = snap(); want = expv(3'd0, 3'd0, 4'd0, 8'd0, 3'b000, 1'b0);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL finish_to_idle got=%h want=%h", got, want); end
  endtask

  task automatic test_skip();
    logic [21:0] got, want;
    int bnd[4] = '{0, 3, 11, 15};
    int dur[4] = '{3, 8, 4, 5};
    int p;
    do_reset();
    load(RINSE_ONLY);
    got = snap(); want = expv(3'd1, 3'd4, 4'd3, 8'd20, 3'b100, 1'b0);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL skip_load got=%h want=%h", got, want); end
    for (int k = 1; k <= 19; k++) begin
      step(1'b1, 1'b0, 1'b0);
      p = 0;
      for (int j = 0; j < 4; j++) if (bnd[j] <= k) p = j;
      got  = snap();
      want = expv(3'd1, 3'(p + 4), 4'(dur[p] - (k - bnd[p])), 8'(20 - k), act_of(3'(p + 4)), 1'b0);
      tests_run++;
      if (got !== want) begin tests_failed++; $display("FAIL skip_tick%0d got=%h want=%h", k, got, want); end
    end
    step(1'b1, 1'b0, 1'b0);
    got = snap(); want = expv(3'd4, 3'd7, 4'd0, 8'd0, 3'b000, 1'b1);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL skip_done got=%h want=%h", got, want); end
  endtask

  task automatic test_single();
    logic [21:0] got, want;
    do_reset();
    load(SPIN_ONLY);
    got = snap(); want = expv(3'd1, 3'd3, 4'd2, 8'd2, 3'b011, 1'b0);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL single_load got=%h want=%h", got, want); end
    ticks(2);
    got = snap(); want = expv(3'd4, 3'd3, 4'd0, 8'd0, 3'b000, 1'b1);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL single_done got=%h want=%h", got, want); end
  endtask

  task automatic test_pause();
    logic [21:0] got, want;
    do_reset();
    load(FULL);
    ticks(5);
    step(1'b0, 1'b0, 1'b1);
    got = snap(); want = expv(3'd2, 3'd1, 4'd8, 8'd37, 3'b000, 1'b0);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL pause_enter got=%h want=%h", got, want); end
    ticks(10);
    got = snap();
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL pause_hold got=%h want=%h", got, want); end
    step(1'b0, 1'b0, 1'b1);
    got = snap(); want = expv(3'd1, 3'd1, 4'd8, 8'd37, 3'b001, 1'b0);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL pause_resume got=%h want=%h", got, want); end
    step(1'b1, 1'b0, 1'b0);
    got = snap(); want = expv(3'd1, 3'd1, 4'd7, 8'd36, 3'b001, 1'b0);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL pause_tick got=%h want=%h", got, want); end
  endtask

  task automatic test_door();
    logic [21:0] got, want;
    do_reset();
    load(FULL);
    ticks(18);
    got = snap(); want = expv(3'd1, 3'd3, 4'd4, 8'd24, 3'b011, 1'b0);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL door_pre got=%h want=%h", got, want); end
    door_open = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    want = expv(3'd3, 3'd3, 4'd4, 8'd24, 3'b000, 1'b0);
    got = snap();
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL door_error got=%h want=%h", got, want); end
    step(1'b0, 1'b1, 1'b0);
    got = snap();
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL door_start_open got=%h want=%h", got, want); end
    step(1'b1, 1'b0, 1'b1);
    door_open = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    got = snap();
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL door_hold got=%h want=%h", got, want); end
    step(1'b0, 1'b1, 1'b0);
    got = snap(); want = expv(3'd1, 3'd3, 4'd4, 8'd24, 3'b011, 1'b0);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL door_resume got=%h want=%h", got, want); end
    step(1'b1, 1'b0, 1'b0);
    got = snap(); want = expv(3'd1, 3'd3, 4'd3, 8'd23, 3'b011, 1'b0);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL door_tick got=%h want=%h", got, want); end
  endtask

  task automatic test_simultaneous();
    logic [21:0] got, want;
    do_reset();
    load(FULL);
    step(1'b1, 1'b0, 1'b1);
    got = snap(); want = expv(3'd2, 3'd0, 4'd3, 8'd42, 3'b000, 1'b0);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL sim_tick_pause got=%h want=%h", got, want); end
    step(1'b0, 1'b0, 1'b1);
    got = snap(); want = expv(3'd1, 3'd0, 4'd3, 8'd42, 3'b100, 1'b0);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL sim_resume got=%h want=%h", got, want); end
    door_open = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    door_open = 1'b0;
    got = snap(); want = expv(3'd3, 3'd0, 4'd3, 8'd42, 3'b000, 1'b0);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL sim_door_pause got=%h want=%h", got, want); end
  endtask

  task automatic test_reset_guards();
    logic [21:0] got, want;
    do_reset();
    load(FULL);
    ticks(26);
    got = snap(); want = expv(3'd1, 3'd5, 4'd7, 8'd16, 3'b001, 1'b0);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL guard_rinse got=%h want=%h", got, want); end
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    got = snap(); want = expv(3'd0, 3'd0, 4'd0, 8'd0, 3'b000, 1'b0);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL guard_midreset got=%h want=%h", got, want); end
    load(26'd0);
    got = snap();
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL guard_zero_prog got=%h want=%h", got, want); end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0; door_open = 1'b0; prog = '0;
    @(negedge cp);
    test_reset();
    test_full();
    test_skip();
    test_single();
    test_pause();
    test_door();
    test_simultaneous();
    test_reset_guards();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
